fft_input_reorder: RTL

Parametrised serial-to-parallel reorder buffer at the front of the radix-4 FFT datapath. Accepts one sample per cycle under a valid/ready handshake and stores complete N-point frames in a ping-pong (double) buffer. Each frame is emitted as N/4 beats of four samples spaced N/4 apart, with the butterfly index, so input can stream continuously while the previous frame drains into the first radix-4 stage.

---
 rtl/fft_input_reorder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fft_input_reorder.sv
// Ping-pong reorder buffer: N-point frames in, N/4 radix-4 beats (x[q], x[q+N/4], x[q+N/2], x[q+3N/4]) out.
// First beat one cycle after a frame completes; in_ready drops only when both banks hold undrained frames.
module fft_input_reorder #(
    parameter int DATA_W = 32,
    parameter int N      = 16,
    localparam int Q_W   = ((N / 4) > 1) ? $clog2(N / 4) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_0,
    output logic [DATA_W-1:0] out_1,
    output logic [DATA_W-1:0] out_2,
    output logic [DATA_W-1:0] out_3,
    output logic [Q_W-1:0]    out_q,
    output logic              out_last
);
    localparam int LOG_N = $clog2(N);
    localparam int QN    = N / 4;

    // Bank b occupies words b*N .. b*N+N-1; address is {bank, offset}.
    logic [DATA_W-1:0] mem_q [2*N];

    logic              wr_bank_q, wr_bank_d;
    logic [LOG_N-1:0]  wr_cnt_q, wr_cnt_d;
    logic              rd_bank_q, rd_bank_d;
    logic [Q_W-1:0]    rd_q_q, rd_q_d;
    logic [1:0]        full_q, full_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_dat_q [4];
    logic [DATA_W-1:0] out_dat_d [4];
    logic [Q_W-1:0]    out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;

    logic              wr_fire;
    logic              launch;
    logic [LOG_N-1:0]  rd_off;

    assign in_ready = !full_q[wr_bank_q];
    assign wr_fire  = in_valid && in_ready;
    assign launch   = full_q[rd_bank_q] && (!out_valid_q || out_ready);

    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_bank_d   = rd_bank_q;
        rd_q_d      = rd_q_q;
        full_d      = full_q;
        out_valid_d = out_valid_q;
        out_dat_d   = out_dat_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        rd_off      = '0;

        if (wr_fire) begin
            if (wr_cnt_q == LOG_N'(N - 1)) begin
                wr_cnt_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + LOG_N'(1);
            end
        end

        // Writes only target a non-full bank and reads only a full one, so the
        // set and clear of full_d below never collide on the same bit.
        if (launch) begin
            for (int k = 0; k < 4; k++) begin
                rd_off       = LOG_N'(k * QN) + LOG_N'(rd_q_q);
                out_dat_d[k] = mem_q[{rd_bank_q, rd_off}];
            end
            out_idx_d   = rd_q_q;
            out_last_d  = (rd_q_q == Q_W'(QN - 1));
            out_valid_d = 1'b1;
            if (rd_q_q == Q_W'(QN - 1)) begin
                rd_q_d            = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end else begin
                rd_q_d = rd_q_q + Q_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[{wr_bank_q, wr_cnt_q}] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_q_q      <= '0;
            full_q      <= 2'b00;
            out_valid_q <= 1'b0;
            out_dat_q   <= '{default: '0};
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_bank_q   <= rd_bank_d;
            rd_q_q      <= rd_q_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_dat_q   <= out_dat_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_0     = out_dat_q[0];
    assign out_1     = out_dat_q[1];
    assign out_2     = out_dat_q[2];
    assign out_3     = out_dat_q[3];
    assign out_q     = out_idx_q;
    assign out_last  = out_last_q;
endmodule
